// File: rtl/game_pkg.sv
// Shared definitions for the move-history block: direction codes, history
// entry layout and FSM state encoding.
package game_pkg;

    typedef enum logic [1:0] {
        DIR_UP    = 2'd0,
        DIR_DOWN  = 2'd1,
        DIR_LEFT  = 2'd2,
        DIR_RIGHT = 2'd3
    } dir_e;

    localparam int HIST_W = 3;

    typedef struct packed {
        logic push;
        dir_e dir;
    } hist_entry_t;

    localparam logic [0:0] S_IDLE      = 1'b0;
    localparam logic [0:0] S_UNDO_WAIT = 1'b1;

endpackage

// File: rtl/game_history_ram.sv
// DEPTH x HIST_W register array holding committed moves: one synchronous
// write port, one combinational read port.
module game_history_ram
    import game_pkg::*;
#(
    parameter int AddrBits = 6,
    parameter int DEPTH    = 64
) (
    input  logic                clk,
    input  logic                we_i,
    input  logic [AddrBits-1:0] waddr_i,
    input  logic [HIST_W-1:0]   wdata_i,
    input  logic [AddrBits-1:0] raddr_i,
    output logic [HIST_W-1:0]   rdata_o
);

    logic [HIST_W-1:0] mem_q [DEPTH];

    // NOTE: the array has no reset; hist_count decides which slots are meaningful.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/game_move_history.sv
// Move-history stack: records committed moves in a ring buffer, presents the
// newest move for undo, and pulses the step counter's inc/dec inputs.
module game_move_history
    import game_pkg::*;
#(
    parameter int AddrBits = 6,
    parameter int DEPTH    = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              level_load,
    input  logic              move_done,
    input  logic [1:0]        move_dir,
    input  logic              move_push,
    input  logic              undo_req,
    input  logic              undo_ack,
    output logic              undo_valid,
    output logic [1:0]        undo_dir,
    output logic              undo_push,
    output logic              step_inc,
    output logic              step_dec,
    output logic [AddrBits:0] hist_count,
    output logic              empty,
    output logic              full
);

    localparam logic [AddrBits:0]   FULL_CNT = (AddrBits + 1)'(DEPTH);
    localparam logic [AddrBits:0]   CNT_ONE  = (AddrBits + 1)'(1);
    localparam logic [AddrBits-1:0] PTR_ONE  = AddrBits'(1);

    logic [0:0]          state_q, state_d;
    logic [AddrBits-1:0] wr_ptr_q, wr_ptr_d, top_ptr;
    logic [AddrBits:0]   count_q, count_d;
    logic                valid_q, valid_d;
    hist_entry_t         undo_q, undo_d;
    hist_entry_t         wr_entry, top_entry;
    logic                inc_q, inc_d;
    logic                dec_q, dec_d;
    logic                empty_q, full_q;
    logic                ram_we;

    assign top_ptr  = wr_ptr_q - PTR_ONE;
    assign wr_entry = '{push: move_push, dir: dir_e'(move_dir)};

    game_history_ram #(
        .AddrBits (AddrBits),
        .DEPTH    (DEPTH)
    ) u_ram (
        .clk     (clk),
        .we_i    (ram_we && !rst),
        .waddr_i (wr_ptr_q),
        .wdata_i (wr_entry),
        .raddr_i (top_ptr),
        .rdata_o (top_entry)
    );

    // NOTE: every signal gets a default first so no path leaves a latch behind.
    always_comb begin
        state_d  = state_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        valid_d  = valid_q;
        undo_d   = undo_q;
        inc_d    = 1'b0;
        dec_d    = 1'b0;
        ram_we   = 1'b0;

        if (level_load) begin
            state_d  = S_IDLE;
            wr_ptr_d = '0;
            count_d  = '0;
            valid_d  = 1'b0;
        end else if (state_q == S_IDLE) begin
            // A move beats a same-cycle undo request; when full the oldest slot is reused.
            if (move_done) begin
                ram_we   = 1'b1;
                wr_ptr_d = wr_ptr_q + PTR_ONE;
                inc_d    = 1'b1;
                if (count_q != FULL_CNT) begin
                    count_d = count_q + CNT_ONE;
                end
            end else if (undo_req && (count_q != '0)) begin
                undo_d  = top_entry;
                valid_d = 1'b1;
                state_d = S_UNDO_WAIT;
            end
        end else begin
            if (undo_ack) begin
                wr_ptr_d = wr_ptr_q - PTR_ONE;
                count_d  = count_q - CNT_ONE;
                valid_d  = 1'b0;
                dec_d    = 1'b1;
                state_d  = S_IDLE;
            end
        end
    end

    // NOTE: state registers use nonblocking assignments so all of them update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            wr_ptr_q <= '0;
            count_q  <= '0;
            valid_q  <= 1'b0;
            undo_q   <= '0;
            inc_q    <= 1'b0;
            dec_q    <= 1'b0;
            empty_q  <= 1'b1;
            full_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            valid_q  <= valid_d;
            undo_q   <= undo_d;
            inc_q    <= inc_d;
            dec_q    <= dec_d;
            empty_q  <= (count_d == '0);
            full_q   <= (count_d == FULL_CNT);
        end
    end

    assign undo_valid = valid_q;
    assign undo_dir   = undo_q.dir;
    assign undo_push  = undo_q.push;
    assign step_inc   = inc_q;
    assign step_dec   = dec_q;
    assign hist_count = count_q;
    assign empty      = empty_q;
    assign full       = full_q;

endmodule

// File: tb/tb_game_move_history.sv
// Self-checking bench for game_move_history: a vector table for the basic
// handshake, a scoreboard queue for wrap/overflow, and hand-written corner cases.
module tb_game_move_history;

    localparam int AddrBits = 6;
    localparam int DEPTH    = 64;

    logic              clk = 1'b0;
    logic              rst;
    logic              level_load;
    logic              move_done;
    logic [1:0]        move_dir;
    logic              move_push;
    logic              undo_req;
    logic              undo_ack;
    logic              undo_valid;
    logic [1:0]        undo_dir;
    logic              undo_push;
    logic              step_inc;
    logic              step_dec;
    logic [AddrBits:0] hist_count;
    logic              empty;
    logic              full;

    int checks = 0;
    int errors = 0;
    int inc_seen = 0;

    game_move_history #(
        .AddrBits (AddrBits),
        .DEPTH    (DEPTH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .level_load (level_load),
        .move_done  (move_done),
        .move_dir   (move_dir),
        .move_push  (move_push),
        .undo_req   (undo_req),
        .undo_ack   (undo_ack),
        .undo_valid (undo_valid),
        .undo_dir   (undo_dir),
        .undo_push  (undo_push),
        .step_inc   (step_inc),
        .step_dec   (step_dec),
        .hist_count (hist_count),
        .empty      (empty),
        .full       (full)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (step_inc) inc_seen++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    typedef struct {
        logic       md;
        logic [1:0] dir;
        logic       push;
        logic       ureq;
        logic       uack;
        logic       ll;
        logic       e_inc;
        logic       e_dec;
        logic       e_valid;
        logic [1:0] e_dir;
        logic       e_push;
        int         e_cnt;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Drive one cycle of inputs from a negedge, release them after the edge,
    // and return at the following negedge where outputs are sampled.
    task automatic drive(input logic md, input logic [1:0] d, input logic p,
                         input logic ureq, input logic uack, input logic ll);
        move_done  = md;
        move_dir   = d;
        move_push  = p;
        undo_req   = ureq;
        undo_ack   = uack;
        level_load = ll;
        @(posedge clk);
        #1;
        move_done  = 1'b0;
        move_dir   = 2'd0;
        move_push  = 1'b0;
        undo_req   = 1'b0;
        undo_ack   = 1'b0;
        level_load = 1'b0;
        @(negedge clk);
    endtask

    task automatic check_outs(input string tag, input logic e_inc, input logic e_dec,
                              input logic e_valid, input logic [1:0] e_dir,
                              input logic e_push, input int e_cnt);
        check({tag, "_inc"},   32'(step_inc),   32'(e_inc));
        check({tag, "_dec"},   32'(step_dec),   32'(e_dec));
        check({tag, "_valid"}, 32'(undo_valid), 32'(e_valid));
        if (e_valid) begin
            check({tag, "_dir"},  32'(undo_dir),  32'(e_dir));
            check({tag, "_push"}, 32'(undo_push), 32'(e_push));
        end
        check({tag, "_count"}, 32'(hist_count), 32'(e_cnt));
        check({tag, "_empty"}, 32'(empty),      32'(e_cnt == 0));
        check({tag, "_full"},  32'(full),       32'(e_cnt == DEPTH));
    endtask

    vec_t        vecs[19];
    logic [2:0]  sb[$];
    logic [2:0]  exp_e;
    logic [1:0]  d;
    logic        p;
    int          inc_base;
    int          hold;

    initial begin
        //           md    dir  push  ureq  uack  ll    inc   dec   val   edir  epush cnt
        vecs[0]  = '{1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 1};
        vecs[1]  = '{1'b1, 2'd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 2};
        vecs[2]  = '{1'b1, 2'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 3};
        vecs[3]  = '{1'b0, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd3, 1'b0, 3};
        vecs[4]  = '{1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd3, 1'b0, 3};
        vecs[5]  = '{1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd3, 1'b0, 3};
        vecs[6]  = '{1'b1, 2'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd3, 1'b0, 3};
        vecs[7]  = '{1'b0, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd3, 1'b0, 3};
        vecs[8]  = '{1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd3, 1'b0, 3};
        vecs[9]  = '{1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 1'b0, 2};
        vecs[10] = '{1'b0, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd2, 1'b1, 2};
        vecs[11] = '{1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 1'b0, 1};
        vecs[12] = '{1'b1, 2'd1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 2};
        vecs[13] = '{1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 2};
        vecs[14] = '{1'b0, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd1, 1'b1, 2};
        vecs[15] = '{1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 0};
        vecs[16] = '{1'b0, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 0};
        vecs[17] = '{1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 0};
        vecs[18] = '{1'b1, 2'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 0};

        rst        = 1'b1;
        level_load = 1'b0;
        move_done  = 1'b0;
        move_dir   = 2'd0;
        move_push  = 1'b0;
        undo_req   = 1'b0;
        undo_ack   = 1'b0;
        repeat (2) @(negedge clk);
        check_outs("reset", 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 0);
        check("reset_dir",  32'(undo_dir),  32'd0);
        check("reset_push", 32'(undo_push), 32'd0);
        rst = 1'b0;

        for (int i = 0; i < 19; i++) begin
            drive(vecs[i].md, vecs[i].dir, vecs[i].push, vecs[i].ureq, vecs[i].uack, vecs[i].ll);
            check_outs($sformatf("vec%0d", i), vecs[i].e_inc, vecs[i].e_dec, vecs[i].e_valid,
                       vecs[i].e_dir, vecs[i].e_push, vecs[i].e_cnt);
        end

        // Wrap and overflow: 70 moves, the scoreboard keeps only the newest DEPTH.
        drive(1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        inc_base = inc_seen;
        for (int i = 0; i < 70; i++) begin
            d = 2'($urandom_range(0, 3));
            p = 1'($urandom_range(0, 1));
            sb.push_back({p, d});
            if (sb.size() > DEPTH) void'(sb.pop_front());
            drive(1'b1, d, p, 1'b0, 1'b0, 1'b0);
            check($sformatf("ovf_inc%0d", i), 32'(step_inc), 32'd1);
        end
        drive(1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("ovf_pulses", 32'(inc_seen - inc_base), 32'd70);
        check_outs("ovf_full", 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, sb.size());

        for (int i = 0; i < DEPTH; i++) begin
            exp_e = sb.pop_back();
            drive(1'b0, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0);
            check_outs($sformatf("pop%0d_req", i), 1'b0, 1'b0, 1'b1, exp_e[1:0], exp_e[2], sb.size() + 1);
            hold = $urandom_range(0, 2);
            for (int h = 0; h < hold; h++) begin
                drive(1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
                check_outs($sformatf("pop%0d_hold", i), 1'b0, 1'b0, 1'b1, exp_e[1:0], exp_e[2], sb.size() + 1);
            end
            drive(1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0);
            check_outs($sformatf("pop%0d_ack", i), 1'b0, 1'b1, 1'b0, 2'd0, 1'b0, sb.size());
        end
        drive(1'b0, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        check_outs("pop65_req", 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 0);
        drive(1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        check_outs("pop65_ack", 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 0);

        // level_load in the middle of an undo with five stored moves.
        for (int i = 0; i < 5; i++) drive(1'b1, 2'(i), 1'b0, 1'b0, 1'b0, 1'b0);
        check_outs("ll_fill", 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 5);
        drive(1'b0, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        check_outs("ll_req", 1'b0, 1'b0, 1'b1, 2'd0, 1'b0, 5);
        drive(1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        check_outs("ll_clear", 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 0);
        drive(1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        check_outs("ll_after", 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 0);

        // Synchronous reset in the middle of an undo.
        drive(1'b1, 2'd2, 1'b1, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 2'd1, 1'b0, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        check_outs("rst_req", 1'b0, 1'b0, 1'b1, 2'd1, 1'b0, 2);
        rst = 1'b1;
        undo_ack = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        undo_ack = 1'b0;
        @(negedge clk);
        check_outs("rst_mid", 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 0);
        drive(1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        check_outs("rst_after", 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/game_move_history.md
# game_move_history

Move-history stack that sits directly upstream of the step counter. It records every committed player move (direction plus box-pushed flag) in a ring buffer. It serves undo requests by presenting the most recent move to the game logic for reversal. It emits the one-cycle increment/decrement pulses that drive the step counter's inc/dec inputs.

## Interface
Parameters:
- AddrBits, 6, log2 of history depth.
- DEPTH, 64, number of stored moves; must equal 2**AddrBits.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- level_load  input  1  pulse; clears history (new level or restart).
- move_done  input  1  pulse; game logic committed one move.
- move_dir  input  2  direction of committed move; UP=0, DOWN=1, LEFT=2, RIGHT=3.
- move_push  input  1  committed move pushed a box.
- undo_req  input  1  pulse from debounced undo key.
- undo_ack  input  1  game logic finished reverting the presented move.
- undo_valid  output  1  an undo entry is presented; held until undo_ack.
- undo_dir  output  2  direction of presented move.
- undo_push  output  1  box-pushed flag of presented move.
- step_inc  output  1  one-cycle pulse to the step counter inc input.
- step_dec  output  1  one-cycle pulse to the step counter dec input.
- hist_count  output  AddrBits+1  entries currently stored, 0..DEPTH.
- empty  output  1  hist_count==0.
- full  output  1  hist_count==DEPTH.

## Operation
- Storage is a ring of DEPTH entries, each 3 bits {push,dir}.
- wr_ptr (AddrBits bits) points at the next write slot. The top entry is at wr_ptr-1, modulo DEPTH.
- FSM states:
  - S_IDLE
  - S_UNDO_WAIT
- Push, in S_IDLE on move_done:
  - Write {move_push,move_dir} at wr_ptr; wr_ptr+1, wrapping DEPTH-1 to 0.
  - hist_count+1, saturating at DEPTH. When full, the oldest entry is silently overwritten.
  - step_inc pulses whether or not the buffer was full.
- Undo, in S_IDLE on undo_req with hist_count>0:
  - Latch the top entry into undo_dir/undo_push, set undo_valid, go to S_UNDO_WAIT.
  - undo_req while empty is ignored: no state change, no pulse.
- In S_UNDO_WAIT on undo_ack:
  - Pop: wr_ptr-1, wrapping 0 to DEPTH-1; hist_count-1.
  - Clear undo_valid, pulse step_dec, return to S_IDLE.
- In S_UNDO_WAIT, move_done and undo_req are ignored, because the game logic is frozen during undo.
- move_done and undo_req together in S_IDLE: move_done wins and undo_req is dropped.
- undo_ack in S_IDLE is ignored.
- level_load has priority over every input except rst:
  - hist_count=0, wr_ptr=0, state S_IDLE, undo_valid=0.
  - No step pulse. The step counter is cleared by its own rst, which the top level ties to level_load.
- Undo count equals the stored count. After DEPTH+k moves, at most DEPTH undos succeed; further undo_req are ignored.

## Timing
- Reset values: state S_IDLE, wr_ptr 0, hist_count 0, undo_valid 0, undo_dir 0, undo_push 0, step_inc 0, step_dec 0, empty 1, full 0. Memory contents are not reset.
- All outputs are registered.
- step_inc is high exactly one cycle, the cycle after the move_done edge.
- step_dec is high exactly one cycle, the cycle after the undo_ack edge.
- undo_valid rises the cycle after the undo_req edge. undo_dir/undo_push are valid in that same cycle and stable until undo_valid falls.
- hist_count, empty and full update in the same cycle as the corresponding pulse.
- Minimum undo turnaround is 2 cycles: undo_ack may arrive in the first cycle undo_valid is high.
- rst or level_load asserted mid-undo: undo_valid drops next cycle and no step_dec is generated.

## Structure
- Shared package game_pkg holds:
  - direction codes DIR_UP/DOWN/LEFT/RIGHT;
  - entry width HIST_W=3;
  - FSM state encoding S_IDLE=0, S_UNDO_WAIT=1.
- One sub-module, game_history_ram: DEPTH x HIST_W register array, one synchronous write port, combinational read port addressed by wr_ptr-1.
- The FSM, pointer/count arithmetic and pulse generation stay in game_move_history.

## Test plan
- Reset, then 3 move_done pulses with dirs 0,2,3 -> three step_inc pulses; hist_count=3; undo_req shows undo_dir=3.
- Undo handshake: undo_req, hold undo_ack low 5 cycles -> undo_valid stays high with stable fields; ack -> step_dec one cycle, hist_count-1, next undo shows dir 2.
- Wrap and overflow: 70 moves with DEPTH=64 -> hist_count=64, full=1, 70 step_inc pulses. 64 undos return moves 70..7 in reverse; the 65th undo_req is ignored with no step_dec.
- undo_req while empty -> undo_valid stays 0, no step_dec.
- Same-cycle move_done+undo_req in S_IDLE -> push only, step_inc, no undo_valid. move_done during S_UNDO_WAIT -> ignored.
- level_load during S_UNDO_WAIT with hist_count=5 -> next cycle undo_valid=0, hist_count=0, empty=1, no step pulses.
